// File: rtl/operand_buffer.sv
// rtl/operand_buffer.sv - 4x4 operand store feeding one edge of the systolic array
module operand_buffer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    write_enable,
    input  logic [1:0]              write_line,
    input  logic [1:0]              write_elem,
    input  logic                    clear,
    input  logic [3:0]              read_enable,
    input  logic [7:0]              read_elem,
    output logic [4*DATA_WIDTH-1:0] data_out,
    output logic [3:0]              valid_out,
    output logic [4:0]              loaded_count,
    output logic                    full
);

    logic [DATA_WIDTH-1:0] mem [4][4];
    logic [15:0]           loaded_mask;
    logic [15:0]           next_mask;
    logic [4:0]            next_count;

    // A write in a clear cycle survives for its own cell only.
    always_comb begin
        next_mask = clear ? 16'h0000 : loaded_mask;
        if (write_enable) begin
            next_mask[{write_line, write_elem}] = 1'b1;
        end
    end

    always_comb begin
        next_count = 5'd0;
        for (int k = 0; k < 16; k++) begin
            next_count = next_count + 5'(next_mask[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int l = 0; l < 4; l++) begin
                for (int e = 0; e < 4; e++) begin
                    mem[l][e] <= '0;
                end
            end
            loaded_mask  <= 16'h0000;
            loaded_count <= 5'd0;
            data_out     <= '0;
            valid_out    <= 4'b0000;
        end else begin
            for (int l = 0; l < 4; l++) begin
                for (int e = 0; e < 4; e++) begin
                    if (write_enable && write_line == 2'(l) && write_elem == 2'(e)) begin
                        mem[l][e] <= data_in;
                    end else if (clear) begin
                        mem[l][e] <= '0;
                    end
                end
            end
            loaded_mask  <= next_mask;
            loaded_count <= next_count;
            // Reads see pre-write, pre-clear contents; idle lanes drive zero.
            for (int i = 0; i < 4; i++) begin
                data_out[i*DATA_WIDTH +: DATA_WIDTH] <=
                    read_enable[i] ? mem[i][read_elem[2*i +: 2]] : '0;
            end
            valid_out <= read_enable;
        end
    end

    assign full = (loaded_count == 5'd16);

endmodule

// File: tb/tb_operand_buffer.sv
// tb/tb_operand_buffer.sv - scoreboard bench for operand_buffer
module tb_operand_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        write_enable;
    logic [1:0]  write_line;
    logic [1:0]  write_elem;
    logic        clear;
    logic [3:0]  read_enable;
    logic [7:0]  read_elem;
    logic [31:0] data_out;
    logic [3:0]  valid_out;
    logic [4:0]  loaded_count;
    logic        full;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        string       name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    operand_buffer #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .write_enable (write_enable),
        .write_line   (write_line),
        .write_elem   (write_elem),
        .clear        (clear),
        .read_enable  (read_enable),
        .read_elem    (read_elem),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .loaded_count (loaded_count),
        .full         (full)
    );

    task automatic drive(input logic we, input logic [1:0] wl, input logic [1:0] welem,
                         input logic [7:0] din, input logic clr, input logic [3:0] ren,
                         input logic [7:0] relem, input logic [31:0] exp_d, input string name);
        exp_t x;
        @(negedge clk);
        write_enable = we;
        write_line   = wl;
        write_elem   = welem;
        data_in      = din;
        clear        = clr;
        read_enable  = ren;
        read_elem    = relem;
        if (ren != 4'b0000) begin
            x.v = ren;
            x.d = exp_d;
            x.name = name;
            sb.push_back(x);
        end
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 4'b0000, 8'h00, 32'h0, "");
    endtask

    task automatic check_count(input logic [4:0] exp_cnt, input logic exp_full, input string name);
        @(posedge clk);
        #2;
        tests++;
        if (loaded_count !== exp_cnt || full !== exp_full) begin
            fails++;
            $display("FAIL %s: loaded_count=%0d full=%0b, required loaded_count=%0d full=%0b",
                     name, loaded_count, full, exp_cnt, exp_full);
        end
    endtask

    task automatic fill();
        for (int idx = 0; idx < 16; idx++) begin
            drive(1'b1, 2'(idx / 4), 2'(idx % 4), 8'(16 * (idx / 4) + (idx % 4)),
                  1'b0, 4'b0000, 8'h00, 32'h0, "");
        end
    endtask

    // Monitor: every presented output is matched against the scoreboard head.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (valid_out !== 4'b0000) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: valid_out=%b data_out=%h, required no output",
                             valid_out, data_out);
                end else begin
                    x = sb.pop_front();
                    if (valid_out !== x.v || data_out !== x.d) begin
                        fails++;
                        $display("FAIL %s: valid_out=%b data_out=%h, required valid_out=%b data_out=%h",
                                 x.name, valid_out, data_out, x.v, x.d);
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0]  en;
        logic [7:0]  el;
        logic [31:0] ex;
        int          e;

        rst_n = 1'b0;
        write_enable = 1'b1; write_line = 2'd1; write_elem = 2'd2; data_in = 8'hFF;
        clear = 1'b0; read_enable = 4'b0000; read_elem = 8'h00;
        repeat (2) @(posedge clk);

        // Release reset with the write still asserted up to that point.
        @(negedge clk);
        rst_n = 1'b1;
        write_enable = 1'b0;
        @(posedge clk);
        #2;
        tests++;
        if (data_out !== 32'h0 || valid_out !== 4'b0000 || loaded_count !== 5'd0 || full !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: data_out=%h valid_out=%b count=%0d full=%0b, required all 0",
                     data_out, valid_out, loaded_count, full);
        end
        drive(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 4'b1111, 8'h00, 32'h00000000, "reset_read_e0");
        drive(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 4'b1111, 8'h55, 32'h00000000, "reset_read_e1");
        drive(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 4'b1111, 8'hAA, 32'h00000000, "reset_read_e2");
        drive(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 4'b1111, 8'hFF, 32'h00000000, "reset_read_e3");

        // Fill with mem[l][e] = 16*l + e; check count near the full boundary.
        for (int idx = 0; idx < 16; idx++) begin
            drive(1'b1, 2'(idx / 4), 2'(idx % 4), 8'(16 * (idx / 4) + (idx % 4)),
                  1'b0, 4'b0000, 8'h00, 32'h0, "");
            if (idx == 14) check_count(5'd15, 1'b0, "count_15");
            if (idx == 15) check_count(5'd16, 1'b1, "full_16");
        end

        // Control skew: lane i active for counter i+1..i+4, element = counter-i-1.
        for (int c = 1; c <= 7; c++) begin
            en = 4'b0000; el = 8'h00; ex = 32'h0;
            for (int i = 0; i < 4; i++) begin
                e = c - 1 - i;
                if (e >= 0 && e <= 3) begin
                    en[i] = 1'b1;
                    el[2*i +: 2] = 2'(e);
                    ex[8*i +: 8] = 8'(16 * i + e);
                end
            end
            drive(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, en, el, ex, $sformatf("skew_c%0d", c));
        end

        // Rewrite of a loaded cell updates data but not the count.
        drive(1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 4'b0000, 8'h00, 32'h0, "");
        check_count(5'd0, 1'b0, "clear_count");
        drive(1'b1, 2'd1, 2'd3, 8'h11, 1'b0, 4'b0000, 8'h00, 32'h0, "");
        check_count(5'd1, 1'b0, "rewrite_first");
        drive(1'b1, 2'd1, 2'd3, 8'h22, 1'b0, 4'b0000, 8'h00, 32'h0, "");
        check_count(5'd1, 1'b0, "rewrite_second");
        drive(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 4'b0010, 8'h0C, 32'h00002200, "rewrite_read");

        // Same-cell read/write collision returns the old value.
        drive(1'b1, 2'd0, 2'd0, 8'hAA, 1'b0, 4'b0000, 8'h00, 32'h0, "");
        drive(1'b1, 2'd0, 2'd0, 8'h55, 1'b0, 4'b0001, 8'h00, 32'h000000AA, "collision_old");
        drive(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 4'b0001, 8'h00, 32'h00000055, "collision_new");

        // Clear with a simultaneous write; the clear-cycle read sees old contents.
        fill();
        check_count(5'd16, 1'b1, "refill_full");
        drive(1'b1, 2'd3, 2'd2, 8'h7E, 1'b1, 4'b0010, 8'h04, 32'h00001100, "clear_cycle_read");
        check_count(5'd1, 1'b0, "clear_write_count");
        drive(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 4'b1001, 8'h80, 32'h7E000000, "clear_write_read");
        drive(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 4'b0110, 8'h3C, 32'h00000000, "cleared_cells");

        // Disabled lanes output zero.
        fill();
        drive(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 4'b0101, 8'hFF, 32'h00230003, "disabled_lanes");

        repeat (3) idle();
        @(posedge clk);
        #3;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL missing_outputs: %0d expected outputs never presented, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
